// File: rtl/key_sec_pkg.sv
// key_sec_pkg
// Shared definitions for the key-path security blocks (tamper detector,
// trojan wrappers, DES wrappers).
//   KEY_W   : DES key width without parity bits
//   ROUNDS  : rounds per encryption
//   RIDX_W  : width of a round index
//   CNT_W   : width of a count that must reach ROUNDS itself
//   state_t : detector run state
package key_sec_pkg;

    localparam int KEY_W  = 56;
    localparam int ROUNDS = 16;
    localparam int RIDX_W = $clog2(ROUNDS);
    localparam int CNT_W  = RIDX_W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/popcount56.sv
// popcount56
// Purely combinational population count of a key-width vector.
// Ports:
//   key   : vector to count (KEY_W bits)
//   count : number of set bits (0..56)
module popcount56
    import key_sec_pkg::*;
(
    input  logic [KEY_W-1:0] key,
    output logic [5:0]       count
);

    always_comb begin
        count = '0;
        for (int i = 0; i < KEY_W; i++) begin
            count = count + 6'(key[i]);
        end
    end

endmodule

// File: rtl/key_tamper_detector.sv
// key_tamper_detector
// Captures a golden copy of the DES key at load time and compares the key
// actually presented to the cipher on each round against it. Mismatching
// rounds and flipped bits are counted, and a sticky alarm is raised when the
// mismatching-round count reaches ALARM_THRESH. The cipher is always fed the
// registered golden key, so a tampered key path is masked downstream.
//
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   key_load/key_in : golden key load strobe and value
//   key_ready       : high in IDLE only
//   round_valid     : one observed round key on key_obs this cycle
//   key_obs         : key as seen at the cipher input
//   key_out         : registered golden key for the cipher
//   tamper_flag     : one-cycle pulse after a mismatching round
//   mismatch_cnt    : mismatching rounds this run (saturates at ROUNDS)
//   bit_err_total   : flipped bits this run (saturating)
//   first_bad_round : first mismatching round index, valid while mismatch_cnt != 0
//   diff_mask       : OR of all observed differences this run
//   alarm/alarm_clr : sticky alarm and its clear (set wins over clear)
//   done            : one-cycle pulse after the last round is sampled
//   state_dbg       : current FSM state
//
// Handshake: key_load is a valid strobe against the key_ready ready signal; a
// load is accepted only on an edge where both are high, and key_load without
// key_ready is dropped, not held. round_valid has no ready: every round_valid
// seen in ARMED is consumed on that edge, and round_valid outside ARMED is
// dropped.
module key_tamper_detector
    import key_sec_pkg::*;
#(
    parameter int ALARM_THRESH = 1,
    parameter int ERR_W        = 10
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              key_load,
    input  logic [KEY_W-1:0]  key_in,
    output logic              key_ready,
    input  logic              round_valid,
    input  logic [KEY_W-1:0]  key_obs,
    output logic [KEY_W-1:0]  key_out,
    output logic              tamper_flag,
    output logic [CNT_W-1:0]  mismatch_cnt,
    output logic [ERR_W-1:0]  bit_err_total,
    output logic [RIDX_W-1:0] first_bad_round,
    output logic [KEY_W-1:0]  diff_mask,
    output logic              alarm,
    input  logic              alarm_clr,
    output logic              done,
    output state_t            state_dbg
);

    // Wide enough to hold the running total plus one round's popcount.
    localparam int SUM_W = ((ERR_W > 6) ? ERR_W : 6) + 1;
    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    state_t            state, state_nxt;
    logic [KEY_W-1:0]  golden;
    logic [RIDX_W-1:0] round_idx;

    logic [KEY_W-1:0]  diff;
    logic [5:0]        diff_bits;
    logic              load_acc;
    logic              sample;
    logic              bad;
    logic              last_round;
    logic [CNT_W-1:0]  cnt_upd;
    logic [SUM_W-1:0]  err_sum;
    logic [ERR_W-1:0]  err_upd;
    logic              alarm_set;

    assign state_dbg = state;

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        key_ready = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                key_ready = 1'b1;
                if (key_load) begin
                    state_nxt = ARMED;
                end
            end
            ARMED: begin
                if (round_valid && last_round) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ---------------- compare datapath ----------------
    assign load_acc   = (state == IDLE) && key_load;
    assign sample     = (state == ARMED) && round_valid;
    assign last_round = (round_idx == RIDX_W'(ROUNDS - 1));
    assign diff       = key_obs ^ golden;
    assign bad        = |diff;

    popcount56 u_pop (
        .key   (diff),
        .count (diff_bits)
    );

    assign cnt_upd = (mismatch_cnt >= CNT_W'(ROUNDS)) ? mismatch_cnt
                                                      : mismatch_cnt + CNT_W'(1);
    assign err_sum = SUM_W'(bit_err_total) + SUM_W'(diff_bits);
    assign err_upd = (err_sum > SUM_W'(ERR_MAX)) ? ERR_MAX : err_sum[ERR_W-1:0];

    // The alarm is set by the arrival of a mismatching round that brings the
    // count to the threshold, not by the count level, so alarm_clr can still
    // clear it while the run statistics are held.
    assign alarm_set = sample && bad && (cnt_upd >= CNT_W'(ALARM_THRESH));

    always_ff @(posedge clk) begin
        if (rst) begin
            golden          <= '0;
            key_out         <= '0;
            round_idx       <= '0;
            mismatch_cnt    <= '0;
            bit_err_total   <= '0;
            first_bad_round <= '0;
            diff_mask       <= '0;
            tamper_flag     <= 1'b0;
            alarm           <= 1'b0;
        end else begin
            tamper_flag <= 1'b0;

            if (load_acc) begin
                golden          <= key_in;
                key_out         <= key_in;
                round_idx       <= '0;
                mismatch_cnt    <= '0;
                bit_err_total   <= '0;
                first_bad_round <= '0;
                diff_mask       <= '0;
            end else if (sample) begin
                round_idx     <= last_round ? '0 : round_idx + RIDX_W'(1);
                bit_err_total <= err_upd;
                diff_mask     <= diff_mask | diff;
                if (bad) begin
                    mismatch_cnt <= cnt_upd;
                    tamper_flag  <= 1'b1;
                    if (mismatch_cnt == '0) begin
                        first_bad_round <= round_idx;
                    end
                end
            end

            if (alarm_set) begin
                alarm <= 1'b1;
            end else if (alarm_clr) begin
                alarm <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_key_tamper_detector.sv
// tb_key_tamper_detector
// Three detector instances share one stimulus stream:
//   u0 : ALARM_THRESH=1, ERR_W=10
//   u1 : ALARM_THRESH=3, ERR_W=10
//   u2 : ALARM_THRESH=1, ERR_W=4
// The reference model keeps the list of per-round differences of the current
// run and derives every statistic from that list.
module tb_key_tamper_detector;
    import key_sec_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic             key_load, round_valid, alarm_clr;
    logic [KEY_W-1:0] key_in, key_obs;

    logic              key_ready[3];
    logic [KEY_W-1:0]  key_out[3];
    logic              tamper_flag[3];
    logic [CNT_W-1:0]  mismatch_cnt[3];
    logic [RIDX_W-1:0] first_bad_round[3];
    logic [KEY_W-1:0]  diff_mask[3];
    logic              alarm[3];
    logic              done[3];
    state_t            state_dbg[3];
    logic [9:0]        bet0, bet1;
    logic [3:0]        bet2;

    key_tamper_detector #(.ALARM_THRESH(1), .ERR_W(10)) u0 (
        .clk(clk), .rst(rst), .key_load(key_load), .key_in(key_in),
        .key_ready(key_ready[0]), .round_valid(round_valid), .key_obs(key_obs),
        .key_out(key_out[0]), .tamper_flag(tamper_flag[0]),
        .mismatch_cnt(mismatch_cnt[0]), .bit_err_total(bet0),
        .first_bad_round(first_bad_round[0]), .diff_mask(diff_mask[0]),
        .alarm(alarm[0]), .alarm_clr(alarm_clr), .done(done[0]),
        .state_dbg(state_dbg[0])
    );

    key_tamper_detector #(.ALARM_THRESH(3), .ERR_W(10)) u1 (
        .clk(clk), .rst(rst), .key_load(key_load), .key_in(key_in),
        .key_ready(key_ready[1]), .round_valid(round_valid), .key_obs(key_obs),
        .key_out(key_out[1]), .tamper_flag(tamper_flag[1]),
        .mismatch_cnt(mismatch_cnt[1]), .bit_err_total(bet1),
        .first_bad_round(first_bad_round[1]), .diff_mask(diff_mask[1]),
        .alarm(alarm[1]), .alarm_clr(alarm_clr), .done(done[1]),
        .state_dbg(state_dbg[1])
    );

    key_tamper_detector #(.ALARM_THRESH(1), .ERR_W(4)) u2 (
        .clk(clk), .rst(rst), .key_load(key_load), .key_in(key_in),
        .key_ready(key_ready[2]), .round_valid(round_valid), .key_obs(key_obs),
        .key_out(key_out[2]), .tamper_flag(tamper_flag[2]),
        .mismatch_cnt(mismatch_cnt[2]), .bit_err_total(bet2),
        .first_bad_round(first_bad_round[2]), .diff_mask(diff_mask[2]),
        .alarm(alarm[2]), .alarm_clr(alarm_clr), .done(done[2]),
        .state_dbg(state_dbg[2])
    );

    // ---------------- scoreboard / reference model ----------------
    int n_checks = 0;
    int n_fail   = 0;

    logic [KEY_W-1:0] exp_q[$];      // differences observed this run
    int               m_phase;       // 0 idle, 1 armed, 2 done
    logic [KEY_W-1:0] m_golden;
    bit               m_tamper;
    bit               m_alarm[3];

    logic [KEY_W-1:0] run_d[ROUNDS]; // per-round injected difference
    bit               run_clr[ROUNDS];

    function automatic int thr_of(input int k);
        return (k == 1) ? 3 : 1;
    endfunction

    function automatic int emax_of(input int k);
        return (k == 2) ? 15 : 1023;
    endfunction

    function automatic int n_bad();
        int n = 0;
        foreach (exp_q[i]) if (exp_q[i] != '0) n++;
        return n;
    endfunction

    function automatic int first_bad();
        foreach (exp_q[i]) if (exp_q[i] != '0) return i;
        return 0;
    endfunction

    function automatic int bit_sum();
        int s = 0;
        foreach (exp_q[i]) s += $countones(exp_q[i]);
        return s;
    endfunction

    function automatic logic [KEY_W-1:0] or_mask();
        logic [KEY_W-1:0] m = '0;
        foreach (exp_q[i]) m |= exp_q[i];
        return m;
    endfunction

    function automatic logic [KEY_W-1:0] rand56();
        return KEY_W'({$urandom(), $urandom()});
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic compare_all();
        int nb, es;
        logic [9:0] bet[3];
        nb = n_bad();
        es = bit_sum();
        bet[0] = bet0;
        bet[1] = bet1;
        bet[2] = 10'(bet2);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("u%0d key_ready", k), 64'(key_ready[k]), 64'(m_phase == 0));
            check($sformatf("u%0d done", k), 64'(done[k]), 64'(m_phase == 2));
            check($sformatf("u%0d key_out", k), 64'(key_out[k]), 64'(m_golden));
            check($sformatf("u%0d tamper_flag", k), 64'(tamper_flag[k]), 64'(m_tamper));
            check($sformatf("u%0d mismatch_cnt", k), 64'(mismatch_cnt[k]), 64'(nb));
            check($sformatf("u%0d bit_err_total", k), 64'(bet[k]),
                  64'((es > emax_of(k)) ? emax_of(k) : es));
            check($sformatf("u%0d diff_mask", k), 64'(diff_mask[k]), 64'(or_mask()));
            check($sformatf("u%0d alarm", k), 64'(alarm[k]), 64'(m_alarm[k]));
            if (nb != 0)
                check($sformatf("u%0d first_bad_round", k), 64'(first_bad_round[k]), 64'(first_bad()));
        end
    endtask

    // Advance one clock, update the model from the inputs the DUT sampled on
    // that edge, then compare every output.
    task automatic tick();
        bit               bad;
        logic [KEY_W-1:0] d;
        int               nb;
        @(posedge clk);
        #1;
        bad = 1'b0;
        if (rst) begin
            m_phase  = 0;
            m_golden = '0;
            exp_q.delete();
            for (int k = 0; k < 3; k++) m_alarm[k] = 1'b0;
        end else begin
            case (m_phase)
                0: if (key_load) begin
                    m_golden = key_in;
                    exp_q.delete();
                    m_phase = 1;
                end
                1: if (round_valid) begin
                    d = key_obs ^ m_golden;
                    exp_q.push_back(d);
                    bad = (d != '0);
                    if (exp_q.size() == ROUNDS) m_phase = 2;
                end
                default: m_phase = 0;
            endcase
            nb = n_bad();
            for (int k = 0; k < 3; k++) begin
                if (bad && nb >= thr_of(k)) m_alarm[k] = 1'b1;
                else if (alarm_clr)         m_alarm[k] = 1'b0;
            end
        end
        m_tamper = bad;
        compare_all();
    endtask

    // ---------------- driver tasks ----------------
    task automatic clear_run();
        for (int r = 0; r < ROUNDS; r++) begin
            run_d[r]   = '0;
            run_clr[r] = 1'b0;
        end
    endtask

    task automatic load_key(input logic [KEY_W-1:0] k);
        key_load = 1'b1;
        key_in   = k;
        tick();
        key_load = 1'b0;
        key_in   = rand56();
    endtask

    // One encryption run. abort_at < ROUNDS pulses rst instead of that round.
    task automatic run(input logic [KEY_W-1:0] key, input int max_gap,
                       input bit noisy, input int abort_at);
        load_key(key);
        for (int r = 0; r < ROUNDS; r++) begin
            if (r == abort_at) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
                return;
            end
            repeat ($urandom_range(max_gap, 0)) begin
                key_obs = rand56();
                if (noisy) begin
                    key_load  = ($urandom_range(3, 0) == 0);
                    key_in    = rand56();
                    alarm_clr = ($urandom_range(7, 0) == 0);
                end
                tick();
                key_load  = 1'b0;
                alarm_clr = 1'b0;
            end
            round_valid = 1'b1;
            key_obs     = key ^ run_d[r];
            alarm_clr   = run_clr[r] | (noisy && ($urandom_range(7, 0) == 0));
            if (noisy) begin
                key_load = 1'($urandom_range(1, 0));
                key_in   = rand56();
            end
            tick();
            round_valid = 1'b0;
            alarm_clr   = 1'b0;
            key_load    = 1'b0;
            key_obs     = rand56();
        end
        tick();
        tick();
    endtask

    task automatic pulse_clr();
        alarm_clr = 1'b1;
        tick();
        alarm_clr = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    localparam logic [KEY_W-1:0] KEY_A = 56'h0123456789ABCD;

    initial begin
        logic [KEY_W-1:0] k;
        rst = 1'b1; key_load = 1'b0; round_valid = 1'b0; alarm_clr = 1'b0;
        key_in = '0; key_obs = '0;
        m_phase = 0; m_golden = '0; m_tamper = 1'b0;
        for (int i = 0; i < 3; i++) m_alarm[i] = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Clean run
        clear_run();
        run(KEY_A, 0, 1'b0, ROUNDS);
        check("clean alarm", 64'(alarm[0]), 64'd0);

        // Single LSB flip in round 5
        clear_run();
        run_d[5] = 56'h1;
        run(KEY_A, 0, 1'b0, ROUNDS);
        check("lsb first_bad_round", 64'(first_bad_round[0]), 64'd5);
        check("lsb diff_mask", 64'(diff_mask[0]), 64'h1);
        check("lsb alarm", 64'(alarm[0]), 64'd1);
        check("lsb key_out", 64'(key_out[0]), 64'(KEY_A));
        pulse_clr();

        // Threshold of three, four flipped bits each in rounds 2, 7, 9
        clear_run();
        run_d[2] = 56'hF0;
        run_d[7] = 56'hF0000;
        run_d[9] = 56'hF << 40;
        run(rand56(), 0, 1'b0, ROUNDS);
        check("thresh bit_err_total", 64'(bet1), 64'd12);
        check("thresh alarm", 64'(alarm[1]), 64'd1);
        pulse_clr();

        // Gaps between rounds and ignored loads while armed
        for (int i = 0; i < 3; i++) begin
            clear_run();
            for (int r = 0; r < ROUNDS; r++)
                if ($urandom_range(3, 0) == 0) run_d[r] = rand56();
            run(rand56(), 5, 1'b1, ROUNDS);
        end

        // Saturation: every bit flipped every round
        clear_run();
        for (int r = 0; r < ROUNDS; r++) run_d[r] = '1;
        run(rand56(), 1, 1'b0, ROUNDS);
        check("sat bit_err_total", 64'(bet2), 64'd15);
        check("sat mismatch_cnt", 64'(mismatch_cnt[2]), 64'd16);

        // Reset after round 8
        clear_run();
        run_d[3] = 56'h80;
        run(rand56(), 2, 1'b0, 9);
        check("midreset mismatch_cnt", 64'(mismatch_cnt[0]), 64'd0);
        check("midreset key_out", 64'(key_out[0]), 64'd0);
        check("midreset alarm", 64'(alarm[0]), 64'd0);

        // Clear coincident with a new mismatch, then a clear that takes effect
        clear_run();
        run_d[3]   = 56'h3;
        run_clr[3] = 1'b1;
        run_clr[10] = 1'b1;
        run(KEY_A, 1, 1'b0, ROUNDS);
        check("clr_late alarm", 64'(alarm[0]), 64'd0);

        // Random runs
        for (int i = 0; i < 20; i++) begin
            clear_run();
            for (int r = 0; r < ROUNDS; r++) begin
                k = '0;
                case ($urandom_range(3, 0))
                    0: k = rand56();
                    1: k = KEY_W'(1) << $urandom_range(KEY_W - 1, 0);
                    default: k = '0;
                endcase
                run_d[r] = k;
            end
            if ($urandom_range(4, 0) == 0)
                run(rand56(), 3, 1'b1, $urandom_range(ROUNDS - 1, 0));
            else
                run(rand56(), 3, 1'b1, ROUNDS);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/key_tamper_detector.md
Name: key_tamper_detector

Overview:
- Defensive counterpart to the key-path trojans inserted in the DES datapath.
- Captures a golden copy of the 56-bit key at load time, then compares the key actually presented to the cipher on each of 16 rounds against that copy.
- Counts mismatching rounds and flipped bits, and raises a sticky alarm at a threshold.
- Always drives the golden key downstream, so a single-bit payload (e.g. LSB flip) is masked.

Parameters:
- KEY_W, 56, key width in bits.
- ROUNDS, 16, rounds per encryption; round counter width is clog2(ROUNDS).
- ALARM_THRESH, 1, mismatching-round count at which alarm asserts (1..ROUNDS).
- ERR_W, 10, width of the saturating flipped-bit accumulator.

Ports:
- clk, input, 1, sole clock; all logic on rising edge.
- rst, input, 1, synchronous, active-high reset.
- key_load, input, 1, load strobe for golden key; accepted only when key_ready=1.
- key_in, input, KEY_W, golden key sampled on an accepted key_load.
- key_ready, output, 1, high in IDLE only.
- round_valid, input, 1, one observed round key presented this cycle.
- key_obs, input, KEY_W, key as seen at the cipher input (possibly tampered).
- key_out, output, KEY_W, registered golden key, to be used by the cipher.
- tamper_flag, output, 1, one-cycle pulse in the cycle after a mismatching round is sampled.
- mismatch_cnt, output, clog2(ROUNDS)+1, mismatching rounds this run, saturating at ROUNDS.
- bit_err_total, output, ERR_W, cumulative flipped bits this run, saturating.
- first_bad_round, output, clog2(ROUNDS), index of first mismatching round; valid while mismatch_cnt≠0.
- diff_mask, output, KEY_W, OR of all (key_obs XOR golden) this run.
- alarm, output, 1, sticky; set when mismatch_cnt ≥ ALARM_THRESH.
- alarm_clr, input, 1, clears alarm (lower priority than a same-cycle set).
- done, output, 1, one-cycle pulse after round ROUNDS-1 is sampled.

Behaviour:
- Reset (rst=1 at edge):
  - state=IDLE; key_out=0; all counters, diff_mask, first_bad_round=0.
  - tamper_flag=0, done=0, alarm=0. key_ready=1 the cycle after reset.
- States: IDLE, ARMED, DONE.
- IDLE:
  - key_ready=1.
  - On key_load: golden←key_in, key_out←key_in, and clear mismatch_cnt, bit_err_total, diff_mask, first_bad_round, round_idx.
  - Go to ARMED next cycle. alarm is not cleared by a load.
  - round_valid in IDLE is ignored.
- ARMED:
  - key_ready=0; key_load ignored.
  - On each round_valid, compute d = key_obs XOR golden:
    - if d≠0: mismatch_cnt++ (saturating); record first_bad_round←round_idx if mismatch_cnt was 0; tamper_flag=1 next cycle.
    - bit_err_total += popcount(d), saturating at 2^ERR_W-1.
    - diff_mask |= d.
    - round_idx++.
  - When round_valid is sampled with round_idx=ROUNDS-1: go to DONE; round_idx wraps to 0.
  - round_valid low: hold all state, no timeout.
- DONE: done=1 for exactly one cycle, then IDLE. Statistics hold until the next accepted key_load.
- Latency: all status outputs update 1 cycle after the sampling edge. key_out updates 1 cycle after an accepted key_load.
- Alarm:
  - Set on the edge where the post-update mismatch_cnt ≥ ALARM_THRESH.
  - alarm_clr clears it only if no set condition occurs in that same cycle.
- Reset mid-run: returns immediately to the reset values above; the partial run is discarded.
- key_obs and key_in are sampled only on the qualifying strobes; X elsewhere is tolerated.

Decomposition:
- Shared package key_sec_pkg holds: KEY_W, ROUNDS, the state enum {IDLE, ARMED, DONE}, and the round-index width constant.
- Shared with the trojan and DES wrappers.
- One sub-module: popcount56, purely combinational, KEY_W in, 6-bit count out. Reused by other detectors.

Test Plan:
- Clean run: load key 56'h0123456789ABCD, 16 round_valid with key_obs equal to it → done pulses once; mismatch_cnt=0, bit_err_total=0, alarm=0, tamper_flag never high.
- LSB-flip payload: same key, round 5 key_obs = key with bit0 inverted → tamper_flag pulse after round 5; first_bad_round=5, mismatch_cnt=1, bit_err_total=1, diff_mask=56'h1; alarm=1; key_out stays the golden key.
- Threshold: ALARM_THRESH=3, flips at rounds 2, 7, 9 with 4 bits each → alarm rises exactly after round 9; bit_err_total=12.
- Gapped/illegal strobes: round_valid gaps of 0–5 cycles, plus key_load during ARMED → load ignored, golden unchanged, done after the 16th valid.
- Saturation: ERR_W=4, every round all-ones diff → bit_err_total=15, mismatch_cnt=16.
- Reset/clear: assert rst after round 8 → all outputs at reset values next cycle. alarm_clr and a new mismatch in the same cycle → alarm stays 1.
